// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and
// default cycle counts, also used by the EX-stage op decode and the stall logic.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  // True for the multi-cycle ops that occupy the unit.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  // True for the divide ops, which use the longer cycle count.
  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_counter.sv
// 4-bit load/decrement counter. Busy while non-zero; done is high during
// the final busy cycle so the owner can commit on the edge that clears it.
module md_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic       o_busy,
  output logic       o_done
);

  logic [3:0] r_cnt;

  // Load on accept, otherwise count down to zero and stay there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == 4'd1);

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Operands latch on accept;
// the result is computed from the latched copies and committed when the
// cycle counter expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic        w_busy;
  logic        w_done;
  logic        w_accept;
  logic [3:0]  w_load_val;

  logic [31:0] r_a;
  logic [31:0] r_b;
  md_op_e      r_op;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_den;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  logic        w_res_we;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_accept   = start && !w_busy && md_is_arith(op);
  assign w_load_val = md_is_div(op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  md_counter u_counter (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .o_busy     (w_busy),
    .o_done     (w_done)
  );

  assign busy = w_busy;

  // Products: operands extended to 64 bits so the truncated product is exact.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'b0, r_a} * {32'b0, r_b};

  // Signed divide via magnitudes; this also yields 0x80000000 / -1 =
  // 0x80000000 with remainder 0 without relying on signed-overflow semantics.
  assign w_a_neg = (r_op == MD_DIV) && r_a[31];
  assign w_b_neg = (r_op == MD_DIV) && r_b[31];
  assign w_a_mag = w_a_neg ? (32'd0 - r_a) : r_a;
  assign w_b_mag = w_b_neg ? (32'd0 - r_b) : r_b;
  assign w_den   = (w_b_mag == '0) ? 32'd1 : w_b_mag;
  assign w_q_mag = w_a_mag / w_den;
  assign w_r_mag = w_a_mag % w_den;
  assign w_quot  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  // Select the result for the latched op; divide by zero leaves HI/LO alone.
  always_comb begin
    w_res_we = 1'b0;
    w_res_hi = '0;
    w_res_lo = '0;
    case (r_op)
      MD_MULT: begin
        w_res_we = 1'b1;
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
      end
      MD_MULTU: begin
        w_res_we = 1'b1;
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        w_res_we = (r_b != '0);
        w_res_hi = w_rem;
        w_res_lo = w_quot;
      end
      default: begin
        w_res_we = 1'b0;
      end
    endcase
  end

  // Operand latch, HI/LO commit, and idle-only mthi/mtlo writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= MD_NONE;
      HI   <= '0;
      LO   <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= A;
        r_b  <= B;
        r_op <= md_op_e'(op);
      end
      if (w_done && w_res_we) begin
        HI <= w_res_hi;
        LO <= w_res_lo;
      end else if (!w_busy && (op == MD_MTHI)) begin
        HI <= A;
      end else if (!w_busy && (op == MD_MTLO)) begin
        LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with default cycle counts.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_errors = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multi-cycle op; checks busy each cycle and HI/LO held until commit.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input string tag);
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0; op = 3'd0; A = $urandom; B = $urandom;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      chk({tag, "_hold_hi"}, HI, old_hi);
      chk({tag, "_hold_lo"}, LO, old_lo);
      tick();
    end
    chk({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; A = '0; B = '0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b1;
    tick();

    // Reset in the middle of a mult
    start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd4;
    tick();
    start = 1'b0; op = 3'd0;
    chk("midrst_busy_pre", {31'b0, busy}, 32'd1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    #2 reset = 1'b1;
    repeat (8) tick();
    chk("midrst_after_busy", {31'b0, busy}, 32'd0);
    chk("midrst_after_hi", HI, 32'd0);
    chk("midrst_after_lo", LO, 32'd0);

    // mult / multu
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h0, 32'h0, "mult");
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);
    run_op(3'd2, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "multu");
    chk("multu_hi", HI, 32'h00000002);
    chk("multu_lo", LO, 32'hFFFFFFFA);

    // signed divides
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h00000002, 32'hFFFFFFFA, "div_neg");
    chk("div_neg_lo", LO, 32'hFFFFFFFD);
    chk("div_neg_hi", HI, 32'hFFFFFFFF);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_ovf");
    chk("div_ovf_lo", LO, 32'h80000000);
    chk("div_ovf_hi", HI, 32'h00000000);

    // mthi / mtlo preload, then divide by zero
    op = 3'd5; A = 32'h11;
    tick();
    op = 3'd0;
    chk("mthi_hi", HI, 32'h11);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    op = 3'd6; A = 32'h22;
    tick();
    op = 3'd0;
    chk("mtlo_lo", LO, 32'h22);
    chk("mtlo_hi", HI, 32'h11);
    run_op(3'd4, 32'd5, 32'd0, 10, 32'h11, 32'h22, "divz");
    chk("divz_hi", HI, 32'h11);
    chk("divz_lo", LO, 32'h22);

    // start while busy is ignored
    start = 1'b1; op = 3'd2; A = 32'd2; B = 32'd2;
    tick();
    start = 1'b0; op = 3'd0;
    chk("sbusy_e0", {31'b0, busy}, 32'd1);
    tick();
    chk("sbusy_e1", {31'b0, busy}, 32'd1);
    start = 1'b1; op = 3'd3; A = 32'd9; B = 32'd3;
    tick();
    start = 1'b0; op = 3'd0;
    chk("sbusy_e2", {31'b0, busy}, 32'd1);
    chk("sbusy_e2_hi", HI, 32'h11);
    tick();
    chk("sbusy_e3", {31'b0, busy}, 32'd1);
    tick();
    chk("sbusy_e4", {31'b0, busy}, 32'd1);
    tick();
    chk("sbusy_e5", {31'b0, busy}, 32'd0);
    chk("sbusy_hi", HI, 32'd0);
    chk("sbusy_lo", LO, 32'd4);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("sbusy_stays_idle", {31'b0, busy}, 32'd0);
    end
    chk("sbusy_final_hi", HI, 32'd0);
    chk("sbusy_final_lo", LO, 32'd4);

    // mthi while busy is ignored; back-to-back mult at the first idle edge
    start = 1'b1; op = 3'd1; A = 32'd7; B = 32'd6;
    tick();
    start = 1'b0; op = 3'd5; A = 32'hAA;
    tick();
    chk("mthib_e1_busy", {31'b0, busy}, 32'd1);
    chk("mthib_e1_hi", HI, 32'd0);
    tick();
    tick();
    tick();
    chk("mthib_e4_busy", {31'b0, busy}, 32'd1);
    chk("mthib_e4_hi", HI, 32'd0);
    start = 1'b1; op = 3'd1; A = 32'h00010000; B = 32'h00010000;
    tick();
    chk("b2b_e5_busy", {31'b0, busy}, 32'd0);
    chk("b2b_first_hi", HI, 32'd0);
    chk("b2b_first_lo", LO, 32'd42);
    tick();
    start = 1'b0; op = 3'd0; A = 32'hDEADBEEF; B = 32'h12345678;
    chk("b2b_e6_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b_busy", {31'b0, busy}, 32'd1);
      chk("b2b_hold_lo", LO, 32'd42);
    end
    tick();
    chk("b2b_busy_fall", {31'b0, busy}, 32'd0);
    chk("b2b_second_hi", HI, 32'd1);
    chk("b2b_second_lo", LO, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
